bist_response_analyzer: RTL and testbench
=========================================

// Module: bist_response_analyzer
// PURPOSE
//   Downstream response stage for golden_design: compacts the 5-bit data_out stream into a MISR signature
//   over a programmed number of test patterns, compares it with a golden signature, and reports pass/fail.
//   Sits between the DUT output and the BIST/DFT controller; one clock domain (refclk).
// PARAMETERS
//   WIDTH  5         response/signature width (matches golden_design data_out)
//   POLY   5'b00101  MISR feedback mask (x^5+x^2+1), XORed in when signature MSB is 1
//   SEED   5'b00000  signature value at reset and at every start
//   CNT_W  8         width of the pattern counter and pattern_count
// PORTS
//   refclk         in   1      sole clock, rising edge
//   reset          in   1      asynchronous, active-low (0 = reset)
//   start          in   1      1-cycle pulse: begin a compaction run (honoured in IDLE and DONE only)
//   pattern_count  in   CNT_W  beats to compact; sampled on accepted start
//   golden_sig     in   WIDTH  expected signature; sampled on accepted start
//   resp_valid     in   1      resp_data qualifier; a beat is accepted when resp_valid=1 in CAPTURE
//   resp_data      in   WIDTH  DUT response (golden_design data_out)
//   busy           out  1      1 in CAPTURE and COMPARE
//   done           out  1      1 in DONE; held until next accepted start or reset
//   pass           out  1      valid when done=1: signature == latched golden_sig
//   signature      out  WIDTH  current MISR contents (live during CAPTURE, frozen after)
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; busy=0, done=0, pass=0, signature=SEED, counter=0.
//   FSM: IDLE -> CAPTURE on start (pattern_count!=0); IDLE -> COMPARE on start with pattern_count==0;
//        CAPTURE -> COMPARE on the edge accepting beat number pattern_count; COMPARE -> DONE (always, 1 cycle);
//        DONE -> CAPTURE/COMPARE on start (same rule as IDLE). start in CAPTURE/COMPARE ignored.
//   On accepted start: signature<=SEED, counter<=0, latch pattern_count and golden_sig, done<=0, pass<=0.
//   MISR update per accepted beat: sig <= {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ resp_data.
//   resp_valid outside CAPTURE: ignored, signature unchanged. resp_valid gaps in CAPTURE: hold state.
//   Counter increments per accepted beat; compare against latched count, no wrap (max 2^CNT_W-1 beats).
//   Latency: last beat accepted at edge k -> COMPARE after edge k; pass and done=1 after edge k+1.
//   pass registered in COMPARE; stays stable while done=1.
//   Simultaneous start and resp_valid in DONE: start wins, that beat is NOT compacted.
//   Reset mid-run: run aborted, all outputs return to reset values immediately.
// STRUCTURE
//   Shared package bist_pkg: state enum (IDLE, CAPTURE, COMPARE, DONE), default WIDTH, POLY, SEED.
//   Sub-module misr_reg (WIDTH, POLY, SEED): clear (load SEED), enable, data in, signature out.
//   Top holds FSM, beat counter, latched pattern_count/golden_sig, pass register.
// TESTING
//   T1 count=5, golden=01000; beats 00001,00100,00011,00111,11111 back-to-back -> signature 01000, pass=1, done 2 cycles after last beat.
//   T2 same beats, golden=01001 -> signature 01000, done=1, pass=0.
//   T3 count=5 with resp_valid=0 gaps between beats -> identical result to T1; busy=1 throughout gaps.
//   T4 count=0, golden=00000 -> no CAPTURE; done=1 two cycles after start, signature 00000, pass=1.
//   T5 reset=0 after 3 beats of T1 -> busy=0, done=0, pass=0, signature=00000 at once; rerun T1 passes.
//   T6 start pulse during CAPTURE and resp_valid in IDLE/DONE -> ignored; T1 result unchanged.

Source files
------------

// File: rtl/bist_response_analyzer_pkg.sv
// rtl/bist_response_analyzer_pkg.sv - shared state type and default parameters for the BIST response analyzer
package bist_pkg;

  localparam int                    BIST_WIDTH = 5;
  localparam int                    BIST_CNT_W = 8;
  localparam logic [BIST_WIDTH-1:0] BIST_POLY  = 5'b00101;
  localparam logic [BIST_WIDTH-1:0] BIST_SEED  = 5'b00000;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    COMPARE,
    DONE
  } bist_state_e;

endpackage

// File: rtl/bist_response_analyzer_if.sv
// rtl/bist_response_analyzer_if.sv - control, response and status signals between BIST controller and analyzer
interface bist_response_analyzer_if
  import bist_pkg::*;
#(
  parameter int WIDTH = BIST_WIDTH,
  parameter int CNT_W = BIST_CNT_W
);

  logic             start;
  logic [CNT_W-1:0] pattern_count;
  logic [WIDTH-1:0] golden_sig;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH-1:0] signature;

  modport master (
    output start, pattern_count, golden_sig, resp_valid, resp_data,
    input  busy, done, pass, signature
  );

  modport slave (
    input  start, pattern_count, golden_sig, resp_valid, resp_data,
    output busy, done, pass, signature
  );

endinterface

// File: rtl/bist_response_analyzer_misr.sv
// rtl/bist_response_analyzer_misr.sv - multiple-input signature register with synchronous clear to seed
module misr_reg #(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] POLY  = 5'b00101,
  parameter logic [WIDTH-1:0] SEED  = 5'b00000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] feedback;

  assign feedback = sig[WIDTH-1] ? POLY : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (clear) begin
      sig <= SEED;
    end else if (enable) begin
      sig <= {sig[WIDTH-2:0], 1'b0} ^ feedback ^ data;
    end
  end

endmodule

// File: rtl/bist_response_analyzer.sv
// rtl/bist_response_analyzer.sv - compacts response beats into a MISR signature and checks it against a golden value
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int               WIDTH = BIST_WIDTH,
  parameter int               CNT_W = BIST_CNT_W,
  parameter logic [WIDTH-1:0] POLY  = BIST_POLY,
  parameter logic [WIDTH-1:0] SEED  = BIST_SEED
) (
  input logic                     refclk,
  input logic                     reset,
  bist_response_analyzer_if.slave bus
);

  bist_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] golden_q;
  logic             pass_q;
  logic             start_ok;
  logic             beat_ok;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    beat_ok  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // start takes priority over a coincident beat; that beat is dropped
        if (bus.start) begin
          start_ok = 1'b1;
          state_d  = (bus.pattern_count == '0) ? COMPARE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.resp_valid) begin
          beat_ok = 1'b1;
          if (cnt_inc == count_q) begin
            state_d = COMPARE;
          end
        end
      end
      COMPARE: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge refclk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      count_q  <= '0;
      golden_q <= '0;
      pass_q   <= 1'b0;
    end else if (start_ok) begin
      cnt_q    <= '0;
      count_q  <= bus.pattern_count;
      golden_q <= bus.golden_sig;
      pass_q   <= 1'b0;
    end else begin
      if (beat_ok) begin
        cnt_q <= cnt_inc;
      end
      if (state_q == COMPARE) begin
        pass_q <= (bus.signature == golden_q);
      end
    end
  end

  misr_reg #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk    (refclk),
    .rst_n  (reset),
    .clear  (start_ok),
    .enable (beat_ok),
    .data   (bus.resp_data),
    .sig    (bus.signature)
  );

  assign bus.busy = (state_q == CAPTURE) || (state_q == COMPARE);
  assign bus.done = (state_q == DONE);
  assign bus.pass = pass_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// tb/tb_bist_response_analyzer.sv - self-checking bench for bist_response_analyzer
module tb_bist_response_analyzer;

  logic refclk;
  logic reset;
  int   errors;
  int   checks;

  bist_response_analyzer_if #(.WIDTH(5), .CNT_W(8)) bus ();

  bist_response_analyzer dut (
    .refclk (refclk),
    .reset  (reset),
    .bus    (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  logic [4:0] beat_mem [256];

  typedef struct {
    string      name;
    int         n;
    logic [4:0] golden;
    int         max_gap;
    logic [4:0] exp_sig;
    logic       exp_pass;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // reference: signature as a plain integer, shifted modulo 32 with x^5 folded back as x^2+1
  function automatic logic [4:0] ref_sig(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s = ((s * 2) % 32) ^ ((s >= 16) ? 5 : 0) ^ int'(beat_mem[i]);
    end
    return 5'(s);
  endfunction

  task automatic load_t1();
    beat_mem[0] = 5'b00001;
    beat_mem[1] = 5'b00100;
    beat_mem[2] = 5'b00011;
    beat_mem[3] = 5'b00111;
    beat_mem[4] = 5'b11111;
  endtask

  task automatic run(input int n, input logic [4:0] g, input int max_gap,
                     output int lat, output int gap_busy_err);
    int gap;
    gap_busy_err   = 0;
    bus.start         = 1'b1;
    bus.pattern_count = 8'(n);
    bus.golden_sig    = g;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      bus.resp_valid = 1'b0;
      for (int j = 0; j < gap; j++) begin
        bus.resp_data = 5'($urandom);
        step();
        if (bus.busy !== 1'b1) gap_busy_err++;
      end
      bus.resp_valid = 1'b1;
      bus.resp_data  = beat_mem[i];
      step();
      bus.resp_valid = 1'b0;
    end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int         lat;
    int         gbe;
    logic [4:0] exp;
    logic [4:0] g;
    int         n;

    errors = 0;
    checks = 0;
    reset             = 1'b0;
    bus.start         = 1'b0;
    bus.pattern_count = '0;
    bus.golden_sig    = '0;
    bus.resp_valid    = 1'b0;
    bus.resp_data     = '0;

    tbl[0] = '{"t1_match",  5, 5'b01000, 0, 5'b01000, 1'b1};
    tbl[1] = '{"t2_miss",   5, 5'b01001, 0, 5'b01000, 1'b0};
    tbl[2] = '{"t3_gaps",   5, 5'b01000, 3, 5'b01000, 1'b1};
    tbl[3] = '{"t4_zero",   0, 5'b00000, 0, 5'b00000, 1'b1};

    step();
    step();
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_pass", int'(bus.pass), 0);
    check("reset_sig", int'(bus.signature), 0);
    reset = 1'b1;
    step();

    // resp_valid while IDLE must not disturb the seed
    bus.resp_valid = 1'b1;
    bus.resp_data  = 5'b10101;
    step();
    step();
    bus.resp_valid = 1'b0;
    check("idle_beat_ignored", int'(bus.signature), 0);

    load_t1();
    for (int t = 0; t < 4; t++) begin
      run(tbl[t].n, tbl[t].golden, tbl[t].max_gap, lat, gbe);
      check({tbl[t].name, "_sig"}, int'(bus.signature), int'(tbl[t].exp_sig));
      check({tbl[t].name, "_pass"}, int'(bus.pass), int'(tbl[t].exp_pass));
      check({tbl[t].name, "_latency"}, lat, 1);
      check({tbl[t].name, "_busy_in_gaps"}, gbe, 0);
      step();
      step();
      check({tbl[t].name, "_done_held"}, int'(bus.done), 1);
      check({tbl[t].name, "_pass_held"}, int'(bus.pass), int'(tbl[t].exp_pass));
    end

    // T5: asynchronous reset mid-run
    bus.start         = 1'b1;
    bus.pattern_count = 8'd5;
    bus.golden_sig    = 5'b01000;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.resp_valid = 1'b1;
      bus.resp_data  = beat_mem[i];
      step();
    end
    bus.resp_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("t5_busy", int'(bus.busy), 0);
    check("t5_done", int'(bus.done), 0);
    check("t5_pass", int'(bus.pass), 0);
    check("t5_sig", int'(bus.signature), 0);
    step();
    reset = 1'b1;
    step();
    run(5, 5'b01000, 0, lat, gbe);
    check("t5_rerun_sig", int'(bus.signature), 8);
    check("t5_rerun_pass", int'(bus.pass), 1);

    // T6: resp_valid in DONE ignored, start during CAPTURE ignored
    bus.resp_valid = 1'b1;
    bus.resp_data  = 5'b11111;
    step();
    step();
    bus.resp_valid = 1'b0;
    check("t6_done_beat_sig", int'(bus.signature), 8);
    check("t6_done_beat_done", int'(bus.done), 1);
    bus.start         = 1'b1;
    bus.pattern_count = 8'd5;
    bus.golden_sig    = 5'b01000;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.resp_valid    = 1'b1;
      bus.resp_data     = beat_mem[i];
      bus.start         = (i == 1 || i == 3);
      bus.pattern_count = 8'd1;
      bus.golden_sig    = 5'b00000;
      step();
    end
    bus.start      = 1'b0;
    bus.resp_valid = 1'b0;
    step();
    check("t6_sig", int'(bus.signature), 8);
    check("t6_pass", int'(bus.pass), 1);
    check("t6_done", int'(bus.done), 1);

    // start and resp_valid together in DONE: start wins, beat dropped
    bus.start         = 1'b1;
    bus.pattern_count = 8'd1;
    bus.golden_sig    = 5'b00000;
    bus.resp_valid    = 1'b1;
    bus.resp_data     = 5'b11111;
    step();
    bus.start = 1'b0;
    check("sim_start_sig", int'(bus.signature), 0);
    check("sim_start_busy", int'(bus.busy), 1);
    check("sim_start_done", int'(bus.done), 0);
    bus.resp_data = 5'b00011;
    step();
    bus.resp_valid = 1'b0;
    step();
    check("sim_start_final_sig", int'(bus.signature), 3);
    check("sim_start_final_pass", int'(bus.pass), 0);
    check("sim_start_final_done", int'(bus.done), 1);

    // randomized runs against the reference model
    for (int r = 0; r < 24; r++) begin
      n = (r == 0) ? 255 : int'($urandom_range(0, 14));
      for (int i = 0; i < n; i++) beat_mem[i] = 5'($urandom);
      exp = ref_sig(n);
      g   = ($urandom_range(0, 1) == 1) ? exp : 5'($urandom);
      run(n, g, int'($urandom_range(0, 2)), lat, gbe);
      check($sformatf("rand%0d_sig", r), int'(bus.signature), int'(exp));
      check($sformatf("rand%0d_pass", r), int'(bus.pass), int'(g == exp));
      check($sformatf("rand%0d_latency", r), lat, 1);
      check($sformatf("rand%0d_busy_in_gaps", r), gbe, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
